// File: rtl/clk_recover_pkg.sv
// Shared constants and helpers for the clk_recover bit-clock recovery block.
package clk_recover_pkg;

  localparam int   OVERSAMPLE_DEF  = 16;
  localparam int   IDLE_BITS_DEF   = 10;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam logic MARK            = 1'b1;

  // Ceiling log2, never narrower than one bit so counters stay declarable.
  function automatic int f_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic logic f_maj3(input logic [2:0] taps);
    return (taps[0] & taps[1]) | (taps[1] & taps[2]) | (taps[0] & taps[2]);
  endfunction

endpackage

// File: rtl/sync_majority.sv
// Metastability synchroniser for rx; CLK_RECOVER_MAJORITY_EN adds a 3-tap
// 2-of-3 majority filter that swallows single-cycle glitches.
module sync_majority
  import clk_recover_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tdi_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  // Chain resets to mark so releasing reset on an idle line is edge-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{MARK}};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef CLK_RECOVER_MAJORITY_EN
  logic [2:0] taps_q;
  logic [2:0] taps_d;

  always_comb begin
    taps_d = {taps_q[1:0], sync_q[SYNC_STAGES-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= {3{MARK}};
    end else begin
      taps_q <= taps_d;
    end
  end

  assign tdi_o = f_maj3(taps_q);
`else
  assign tdi_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/clk_recover.sv
// Oversampling bit-clock recovery: phase counter re-phased on every data edge,
// mid-bit sampler, idle/lock tracking. Build option: CLK_RECOVER_MAJORITY_EN.
module clk_recover
  import clk_recover_pkg::*;
#(
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int SAMPLE_POINT = OVERSAMPLE / 2,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int IDLE_BITS    = IDLE_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tck,
  output logic tdi,
  output logic bit_valid,
  output logic bit_data,
  output logic locked,
  output logic line_idle
);

  localparam int              CW         = f_clog2(OVERSAMPLE);
  localparam int              IW         = f_clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_SAMPLE = CW'(SAMPLE_POINT);
  localparam logic [IW-1:0]   IDLE_FULL  = IW'(IDLE_BITS);

  logic          tdi_s;
  logic          edge_s;
  logic          tdi_dly_q;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          tck_q,       tck_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_data_q,  bit_data_d;
  logic [IW-1:0] idle_cnt_q,  idle_cnt_d;
  logic          line_idle_q, line_idle_d;
  logic          locked_q,    locked_d;

  sync_majority #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx),
    .tdi_o(tdi_s)
  );

  assign edge_s = (tdi_s != tdi_dly_q);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // tck and the sample strobe look at the pre-update counter, so an edge only
  // shifts them through the counter value it leaves behind.
  always_comb begin
    tck_d       = (cnt_q >= CNT_SAMPLE);
    bit_valid_d = (cnt_q == CNT_SAMPLE) && !edge_s;
    if (bit_valid_d) begin
      bit_data_d = tdi_s;
    end else begin
      bit_data_d = bit_data_q;
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (edge_s || (tdi_s != MARK)) begin
      idle_cnt_d = '0;
    end else if ((cnt_q == CNT_LAST) && (idle_cnt_q != IDLE_FULL)) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // An edge outranks the idle declaration when both land together.
  always_comb begin
    line_idle_d = (idle_cnt_q == IDLE_FULL);
    if (edge_s) begin
      locked_d = 1'b1;
    end else if (line_idle_d && !line_idle_q) begin
      locked_d = 1'b0;
    end else begin
      locked_d = locked_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdi_dly_q   <= MARK;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= MARK;
      idle_cnt_q  <= '0;
      line_idle_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      tdi_dly_q   <= tdi_s;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      idle_cnt_q  <= idle_cnt_d;
      line_idle_q <= line_idle_d;
      locked_q    <= locked_d;
    end
  end

  assign tdi       = tdi_s;
  assign tck       = tck_q;
  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign locked    = locked_q;
  assign line_idle = line_idle_q;

endmodule

// File: tb/tb_clk_recover.sv
// Directed bench for clk_recover: frame table plus hand-written corner sequences.
module tb_clk_recover;

`ifdef CLK_RECOVER_MAJORITY_EN
  localparam int FILT = 2;
`else
  localparam int FILT = 0;
`endif
  localparam int LAT = 2 + FILT;

  logic clk, rst, rx, rx2;
  logic tck, tdi, bit_valid, bit_data, locked, line_idle;
  logic tck2, tdi2, bv2, bd2, lk2, li2;

  int checks = 0;
  int errors = 0;

  clk_recover dut (
    .clk(clk), .rst(rst), .rx(rx), .tck(tck), .tdi(tdi), .bit_valid(bit_valid),
    .bit_data(bit_data), .locked(locked), .line_idle(line_idle)
  );

  clk_recover #(.OVERSAMPLE(12), .SAMPLE_POINT(6)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .tck(tck2), .tdi(tdi2), .bit_valid(bv2),
    .bit_data(bd2), .locked(lk2), .line_idle(li2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tck"}, 32'(tck), 32'd0);
    chk({tag, "_tdi"}, 32'(tdi), 32'd1);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_bit_data"}, 32'(bit_data), 32'd1);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_line_idle"}, 32'(line_idle), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;  // bit k = k-th received bit (start first, stop last)
  } frame_t;

  frame_t frames[5];

  initial begin
    logic [9:0]  bits;
    logic [9:0]  got;
    logic [19:0] pat;
    logic [19:0] got20;
    int n, bad_t, p, first, rises, bad_rise, data0, idle_at, lk_seen, first_data;
    int maxcnt;
    logic prev_tck, prev_lk, done;

    frames[0] = '{8'h55, 10'b1010101010};
    frames[1] = '{8'hA5, 10'b1101001010};
    frames[2] = '{8'h00, 10'b1000000000};
    frames[3] = '{8'hFF, 10'b1111111110};
    frames[4] = '{8'h80, 10'b1100000000};

    rst = 1'b1; rx = 1'b1; rx2 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("rst0");

    // Idle line after reset.
    rises = 0; bad_rise = 0; data0 = 0; idle_at = 0; lk_seen = 0; n = 0;
    prev_tck = tck;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (tck && !prev_tck) begin
        rises++;
        if ((i - 9) % 16 != 0) bad_rise++;
      end
      prev_tck = tck;
      if (bit_valid) begin
        n++;
        if (!bit_data) data0++;
      end
      if (line_idle && idle_at == 0) idle_at = i;
      if (locked) lk_seen++;
    end
    chk("idle_tck_rises", 32'(rises), 32'd12);
    chk("idle_tck_period", 32'(bad_rise), 32'd0);
    chk("idle_strobes", 32'(n), 32'd12);
    chk("idle_data0", 32'(data0), 32'd0);
    chk("idle_line_idle_at", 32'(idle_at), 32'd161);
    chk("idle_locked", 32'(lk_seen), 32'd0);

    // 1-cycle low glitch on idle line.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    first = 0;
    for (int c = 0; c < 30; c++) begin
      rx = (c == 0) ? 1'b0 : 1'b1;
      tick();
      if (bit_valid && first == 0) first = c + 1;
    end
`ifdef CLK_RECOVER_MAJORITY_EN
    chk("glitch_first_strobe", 32'(first), 32'd5);
    chk("glitch_locked", 32'(locked), 32'd0);
`else
    chk("glitch_first_strobe", 32'(first), 32'd13);
    chk("glitch_locked", 32'(locked), 32'd1);
`endif

    // Frame table: start + 8 data LSB first + stop, 16 clocks per bit.
    for (int f = 0; f < 5; f++) begin
      bits = {1'b1, frames[f].data, 1'b0};
      n = 0; got = '0; bad_t = 0;
      for (int c = 0; c < 160; c++) begin
        rx = bits[c / 16];
        tick();
        p = c + 1;
        if (p >= LAT + 2 && bit_valid) begin
          if (n < 10) begin
            got[n] = bit_data;
            if (p != LAT + 10 + 16 * n) bad_t++;
          end
          n++;
        end
      end
      chk($sformatf("frame%0d_count", f), 32'(n), 32'd10);
      chk($sformatf("frame%0d_bits", f), 32'(got), 32'(frames[f].exp_bits));
      chk($sformatf("frame%0d_timing", f), 32'(bad_t), 32'd0);
      chk($sformatf("frame%0d_locked", f), 32'(locked), 32'd1);
      rx = 1'b1;
      for (int i = 0; i < 40; i++) tick();
    end

    // locked drops exactly when line_idle rises.
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      prev_lk = locked;
      tick();
      if (line_idle) begin
        done = 1'b1;
        chk("idle_drop_locked_now", 32'(locked), 32'd0);
        chk("idle_drop_locked_before", 32'(prev_lk), 32'd1);
      end
    end
    chk("idle_drop_seen", 32'(done), 32'd1);

    // Edge arriving while cnt == SAMPLE_POINT.
    first = 0; first_data = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      rx = (c < LAT + 7) ? 1'b0 : 1'b1;
      tick();
      p = c + 1;
      if (p >= LAT + 2 && bit_valid) begin
        if (first == 0) begin
          first = p;
          first_data = int'(bit_data);
        end
        n++;
      end
    end
    chk("edge_at_sp_first", 32'(first), 32'(LAT + 19));
    chk("edge_at_sp_data", 32'(first_data), 32'd1);
    chk("edge_at_sp_count", 32'(n), 32'd2);

    // Reset pulse in the middle of a low bit.
    rx = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_state("rst_mid");
    first = 0; first_data = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bit_valid && first == 0) begin
        first = c + 1;
        first_data = int'(bit_data);
      end
    end
    chk("rst_mid_first_strobe", 32'(first), 32'(LAT + 10));
    chk("rst_mid_data", 32'(first_data), 32'd0);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // OVERSAMPLE=12 instance, each bit 13 clocks long (+1 cycle drift per bit).
    pat = 20'b0010_1101_0011_1001_0110;
    n = 0; got20 = '0; maxcnt = 0;
    for (int c = 0; c < 264 + LAT; c++) begin
      rx2 = (c < 260) ? pat[c / 13] : 1'b1;
      tick();
      p = c + 1;
      if (int'(dut2.cnt_q) > maxcnt) maxcnt = int'(dut2.cnt_q);
      if (p >= LAT + 2 && bv2) begin
        if (n < 20) got20[n] = bd2;
        n++;
      end
    end
    chk("drift_count", 32'(n), 32'd20);
    chk("drift_bits", 32'(got20), 32'(pat));
    chk("drift_cnt_max", 32'(maxcnt <= 11), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
